// File: rtl/elc3_mmio.sv
// eLC-3 memory-mapped device responder: keyboard, display and machine-control
// registers with a registered Ready handshake on the CPU memory bus.
module elc3_mmio #(
    parameter int SYNC_STAGES      = 2,
    parameter int DISP_BUSY_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Reset_N,
    input  logic [15:0] Addr,
    input  logic        MIO_EN,
    input  logic        R_W,
    input  logic [15:0] Data_In,
    output logic [15:0] Data_Out,
    output logic        Hit,
    output logic        Ready,
    input  logic [15:0] SW,
    input  logic        Key_N,
    output logic [15:0] Disp,
    output logic        Irq_Kbd,
    output logic        Halt
);
    localparam logic [15:0] A_KBSR = 16'hFE00;
    localparam logic [15:0] A_KBDR = 16'hFE02;
    localparam logic [15:0] A_DSR  = 16'hFE04;
    localparam logic [15:0] A_DDR  = 16'hFE06;
    localparam logic [15:0] A_MCR  = 16'hFFFE;
    localparam int CW = $clog2(DISP_BUSY_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;
    state_t state;

    logic [SYNC_STAGES-1:0] sync;
    logic                   key_prev;
    logic                   kb_rdy, kb_ie, dsr_rdy;
    logic [15:0]            kbdr, mcr;
    logic [CW-1:0]          busy_cnt;
    logic                   accept, wr, rd, press;
    logic [15:0]            rdata;

    assign Hit    = (Addr == A_KBSR) || (Addr == A_KBDR) || (Addr == A_DSR) ||
                    (Addr == A_DDR)  || (Addr == A_MCR);
    assign accept = (state == IDLE) && MIO_EN && Hit;
    assign wr     = accept && R_W;
    assign rd     = accept && !R_W;
    assign press  = key_prev && !sync[SYNC_STAGES-1];

    assign Irq_Kbd = kb_rdy && kb_ie;
    assign Halt    = !mcr[15];

    always_comb begin
        rdata = 16'h0000;
        case (Addr)
            A_KBSR:  rdata = {kb_rdy, kb_ie, 14'h0000};
            A_KBDR:  rdata = kbdr;
            A_DSR:   rdata = {dsr_rdy, 15'h0000};
            A_MCR:   rdata = mcr;
            default: rdata = 16'h0000;
        endcase
    end

    // Handshake FSM; Data_Out only changes on an accepted read
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state    <= IDLE;
            Ready    <= 1'b0;
            Data_Out <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    Ready <= accept;
                    if (accept) state <= ACK;
                    if (rd) Data_Out <= rdata;
                end
                ACK: begin
                    Ready <= 1'b0;
                    state <= MIO_EN ? HOLD : IDLE;
                end
                default: begin
                    Ready <= 1'b0;
                    if (!MIO_EN) state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            sync     <= '1;
            key_prev <= 1'b1;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], Key_N};
            key_prev <= sync[SYNC_STAGES-1];
        end
    end

    // A KBDR read on the press edge frees the slot, so the new key still lands
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            kb_rdy <= 1'b0;
            kb_ie  <= 1'b0;
            kbdr   <= 16'h0000;
        end else begin
            if (press && (!kb_rdy || (rd && Addr == A_KBDR))) begin
                kb_rdy <= 1'b1;
                kbdr   <= SW;
            end else if (rd && Addr == A_KBDR) begin
                kb_rdy <= 1'b0;
            end
            if (wr && Addr == A_KBSR) kb_ie <= Data_In[14];
        end
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            dsr_rdy  <= 1'b1;
            busy_cnt <= '0;
            Disp     <= 16'h0000;
            mcr      <= 16'h8000;
        end else begin
            if (wr && Addr == A_DDR && dsr_rdy) begin
                Disp     <= Data_In;
                dsr_rdy  <= 1'b0;
                busy_cnt <= CW'(DISP_BUSY_CYCLES);
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - 1'b1;
                if (busy_cnt == CW'(1)) dsr_rdy <= 1'b1;
            end
            if (wr && Addr == A_MCR) mcr <= Data_In;
        end
    end
endmodule

// File: tb/tb_elc3_mmio.sv
// Directed self-checking bench for elc3_mmio with hand-computed expectations.
module tb_elc3_mmio;
    logic        Clk = 1'b0;
    logic        Reset_N;
    logic [15:0] Addr, Data_In, Data_Out, SW, Disp;
    logic        MIO_EN, R_W, Hit, Ready, Key_N, Irq_Kbd, Halt;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] q;
    int          cnt;

    elc3_mmio #(.SYNC_STAGES(2), .DISP_BUSY_CYCLES(16)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .Addr(Addr), .MIO_EN(MIO_EN), .R_W(R_W),
        .Data_In(Data_In), .Data_Out(Data_Out), .Hit(Hit), .Ready(Ready),
        .SW(SW), .Key_N(Key_N), .Disp(Disp), .Irq_Kbd(Irq_Kbd), .Halt(Halt)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // One bus access: Ready must come one edge after the request, then drop
    task automatic bus(input string tag, input logic rw, input logic [15:0] a,
                       input logic [15:0] d, output logic [15:0] rq);
        int n;
        Addr = a; R_W = rw; Data_In = d; MIO_EN = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!Ready && n < 8);
        chk({tag, "_lat"}, 16'(n), 16'd1);
        rq = Data_Out;
        MIO_EN = 1'b0;
        step(1);
        chk({tag, "_rdy_drop"}, {15'h0, Ready}, 16'h0);
    endtask

    task automatic key(input logic [15:0] sw);
        SW = sw; Key_N = 1'b0;
        step(4);
        Key_N = 1'b1;
        step(4);
    endtask

    initial begin
        Reset_N = 1'b0; MIO_EN = 1'b0; R_W = 1'b0; Addr = 16'h0; Data_In = 16'h0;
        SW = 16'h0; Key_N = 1'b1;
        step(2);
        Reset_N = 1'b1;
        step(1);

        // Reset asserted while Ready is high
        Addr = 16'hFE04; R_W = 1'b0; MIO_EN = 1'b1;
        step(1);
        chk("pre_rst_ready", {15'h0, Ready}, 16'h1);
        Reset_N = 1'b0;
        #1;
        chk("rst_ready", {15'h0, Ready}, 16'h0);
        chk("rst_dout", Data_Out, 16'h0000);
        chk("rst_disp", Disp, 16'h0000);
        chk("rst_halt", {15'h0, Halt}, 16'h0);
        chk("rst_irq", {15'h0, Irq_Kbd}, 16'h0);
        MIO_EN = 1'b0;
        step(1);
        Reset_N = 1'b1;
        step(1);
        chk("hit_fe04", {15'h0, Hit}, 16'h1);
        bus("rd_dsr", 1'b0, 16'hFE04, 16'h0, q); chk("dsr_rst", q, 16'h8000);
        bus("rd_mcr", 1'b0, 16'hFFFE, 16'h0, q); chk("mcr_rst", q, 16'h8000);

        // Single key press
        key(16'h0041);
        bus("rd_kbsr1", 1'b0, 16'hFE00, 16'h0, q); chk("kbsr_pend", q, 16'h8000);
        bus("rd_kbdr1", 1'b0, 16'hFE02, 16'h0, q); chk("kbdr_41", q, 16'h0041);
        bus("rd_kbsr2", 1'b0, 16'hFE00, 16'h0, q); chk("kbsr_clr", q, 16'h0000);

        // Overrun, then a read coincident with a new press
        key(16'h0041);
        key(16'h0042);
        SW = 16'h0043; Key_N = 1'b0;
        step(2);
        bus("rd_kbdr_co", 1'b0, 16'hFE02, 16'h0, q); chk("kbdr_overrun", q, 16'h0041);
        Key_N = 1'b1;
        step(4);
        bus("rd_kbsr3", 1'b0, 16'hFE00, 16'h0, q); chk("kbsr_co", q, 16'h8000);
        bus("rd_kbdr2", 1'b0, 16'hFE02, 16'h0, q); chk("kbdr_43", q, 16'h0043);

        // Display busy window; first write accepted at edge N
        bus("wr_ddr1", 1'b1, 16'hFE06, 16'h1234, q);
        chk("disp_1234", Disp, 16'h1234);
        bus("rd_dsr_busy", 1'b0, 16'hFE04, 16'h0, q); chk("dsr_busy", q, 16'h0000);
        bus("wr_ddr_busy", 1'b1, 16'hFE06, 16'h5678, q);
        chk("disp_keep", Disp, 16'h1234);
        step(9);
        bus("rd_dsr_n15", 1'b0, 16'hFE04, 16'h0, q); chk("dsr_n15", q, 16'h0000);
        bus("rd_dsr_n17", 1'b0, 16'hFE04, 16'h0, q); chk("dsr_ready", q, 16'h8000);
        bus("rd_ddr", 1'b0, 16'hFE06, 16'h0, q); chk("ddr_rd0", q, 16'h0000);

        // Interrupt enable and press latency seen on Irq_Kbd
        bus("wr_kbsr", 1'b1, 16'hFE00, 16'h4000, q);
        chk("irq_idle", {15'h0, Irq_Kbd}, 16'h0);
        bus("rd_kbsr_ie", 1'b0, 16'hFE00, 16'h0, q); chk("kbsr_ie", q, 16'h4000);
        SW = 16'h0055; Key_N = 1'b0;
        step(2);
        chk("irq_e2", {15'h0, Irq_Kbd}, 16'h0);
        step(1);
        chk("irq_e3", {15'h0, Irq_Kbd}, 16'h1);
        Key_N = 1'b1;
        step(4);
        bus("wr_kbdr_ro", 1'b1, 16'hFE02, 16'h9999, q);
        bus("rd_kbdr3", 1'b0, 16'hFE02, 16'h0, q); chk("kbdr_ro", q, 16'h0055);

        // Machine control
        bus("wr_mcr0", 1'b1, 16'hFFFE, 16'h0000, q);
        chk("halt_on", {15'h0, Halt}, 16'h1);
        bus("rd_mcr0", 1'b0, 16'hFFFE, 16'h0, q); chk("mcr_0", q, 16'h0000);
        bus("wr_mcr1", 1'b1, 16'hFFFE, 16'h8000, q);
        chk("halt_off", {15'h0, Halt}, 16'h0);

        // Non-hit address never acknowledged
        Addr = 16'h3000; R_W = 1'b0; MIO_EN = 1'b1;
        #1;
        chk("hit_3000", {15'h0, Hit}, 16'h0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (Ready) cnt++;
        end
        chk("nohit_ready", 16'(cnt), 16'd0);
        MIO_EN = 1'b0;
        step(1);

        // Held request yields one pulse only
        Addr = 16'hFE04; MIO_EN = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (Ready) cnt++;
        end
        chk("hold_pulses", 16'(cnt), 16'd1);
        MIO_EN = 1'b0;
        step(2);
        bus("rd_after_hold", 1'b0, 16'hFE04, 16'h0, q); chk("dsr_after_hold", q, 16'h8000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/elc3_mmio.md
# elc3_mmio

Memory-mapped I/O responder for the eLC-3 datapath. It sits on the CPU memory bus beside the SRAM path and decodes the LC-3 device-register window: keyboard (KBSR/KBDR), display (DSR/DDR) and machine control (MCR). It answers each CPU request with a registered `Ready` handshake. Switch/key input feeds the keyboard registers; DDR writes drive a latched display value with a modelled busy interval.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `Key_N`; legal range ≥2.
- `DISP_BUSY_CYCLES`, 16: cycles DSR[15] stays clear after an accepted DDR write; legal range ≥1.
- `Clk` in 1: the block's single clock; all state updates on its rising edge.
- `Reset_N` in 1: asynchronous, active-low reset.
- `Addr` in 16: bus address (MAR).
- `MIO_EN` in 1: memory request; held high until `Ready` is seen.
- `R_W` in 1: 1 = write, 0 = read.
- `Data_In` in 16: write data (MDR).
- `Data_Out` out 16: registered read data.
- `Hit` out 1: combinational; `Addr` ∈ {xFE00, xFE02, xFE04, xFE06, xFFFE}.
- `Ready` out 1: registered one-cycle acknowledge.
- `SW` in 16: keyboard data source.
- `Key_N` in 1: asynchronous active-low keyboard strobe button.
- `Disp` out 16: last accepted DDR value.
- `Irq_Kbd` out 1: KBSR[15] & KBSR[14].
- `Halt` out 1: ~MCR[15].

## Operation
- Registers:
  - KBSR xFE00: bit15 ready (read-only), bit14 IE (read/write); all other bits read 0.
  - KBDR xFE02: read-only.
  - DSR xFE04: bit15 ready (read-only); all other bits read 0.
  - DDR xFE06: write-only; reads return 0.
  - MCR xFFFE: bit15 clock enable; write stores all 16 bits.
  - Writes to read-only registers are ignored but still acknowledged.
- Reset values:
  - KBSR=0, KBDR=0, DSR=x8000, Disp=0, MCR=x8000.
  - Data_Out=0, Ready=0, busy counter=0, FSM=IDLE, synchronizer flops=1.
  - Halt=0, Irq_Kbd=0.
- FSM states:
  - IDLE: on MIO_EN & Hit → ACK. At that edge, read data is loaded into Data_Out and write or read side-effects commit. Non-hit requests are ignored, so the SRAM path answers them.
  - ACK: Ready=1. If MIO_EN is still high → HOLD, else → IDLE.
  - HOLD: Ready=0; waits for MIO_EN low → IDLE. This prevents a double acknowledge.
- Keyboard:
  - `Key_N` passes through SYNC_STAGES flops; a 1→0 transition on the synchronized signal is a press event.
  - Press when KBSR[15]=0: KBDR←SW, KBSR[15]←1.
  - Press when KBSR[15]=1 (overrun): the press is dropped and KBDR keeps the old value.
  - A read of KBDR clears KBSR[15] at the commit edge.
  - Same-edge KBDR read and press: the read returns the old KBDR; the press then sets KBSR[15] and loads the new SW.
- Display:
  - DDR write when DSR[15]=1: Disp←Data_In, DSR[15]←0, counter←DISP_BUSY_CYCLES.
  - While the counter is nonzero it decrements; on reaching 0, DSR[15]←1.
  - DDR write when DSR[15]=0: data dropped, Disp unchanged, Ready still given.
- MCR: writing bit15=0 asserts Halt, which holds until rewritten or reset.
- Reset mid-access: all state returns to reset values at once; Ready drops immediately, and the CPU re-issues the request.

## Timing
- Request sampled at edge N → Ready high during cycle N+1 for exactly one cycle. Data_Out is valid from edge N and holds until the next accepted read.
- Minimum spacing between acknowledges is 2 cycles; MIO_EN must drop for ≥1 cycle between requests.
- Key press latency: KBSR[15] is set SYNC_STAGES+1 edges after `Key_N` falls (stable input).
- Accepted DDR write at edge N → DSR[15]=0 from edge N, =1 again at edge N+DISP_BUSY_CYCLES.
- Irq_Kbd and Halt are combinational from registers, so they follow their register edge with zero extra latency.
- Hit is purely combinational from Addr and has no registered delay.

## Test plan
- Reset with Reset_N=0 mid-ACK → Ready=0 immediately and the reset values listed above hold. Then read DSR → Data_Out=x8000, with Ready one cycle after the request.
- SW=x0041, pulse Key_N low → KBSR reads x8000. Then read KBDR → x0041, followed by KBSR read → x0000.
- Two presses (SW=x0041, then x0042) without reading → KBDR=x0041 (overrun dropped). Then read KBDR coincident with a third press (SW=x0043) → the read returns x0041, then KBSR=x8000 and KBDR=x0043.
- Write DDR=x1234 → Disp=x1234 and DSR=x0000 for 16 cycles, then x8000. A DDR=x5678 write during busy → Disp stays x1234, and Ready still pulses.
- Write KBSR=x4000 with a pending key → Irq_Kbd=1. Write MCR=x0000 → Halt=1, and MCR reads x0000.
- Access Addr=x3000 → Hit=0 and Ready never asserts. Hold MIO_EN high 5 cycles on a hit → exactly one Ready pulse.
